// File: rtl/bridge_phase_seq.sv
// 4-phase H-bridge gate sequencer driven by the divider quarter-period strobe, with dead time and burst count.
// Optional low-side brake after normal completion: define BRIDGE_SEQ_BRAKE_EN.
module bridge_phase_seq #(
    parameter int CNT_W = 12,
    parameter int DT_W  = 4
) (
    input  logic             clk_sys,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] cyc_num,
    input  logic [DT_W-1:0]  dead_num,
    input  logic             start,
    input  logic             stop,
    input  logic             clk_4f_en,
    output logic             bri_div_start,
    output logic             gate_ah,
    output logic             gate_al,
    output logic             gate_bh,
    output logic             gate_bl,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [1:0]       state_dbg
);

    // Handshake: start/load are sampled on a rising edge only in IDLE; clk_4f_en is a
    // one-cycle strobe acted on only in ARM/RUN; done is a one-cycle pulse, no ready.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam logic [3:0] GATES_OFF = 4'b0000;

    state_t           state_q, state_d;
    logic [1:0]       phase_q, phase_d;
    logic [CNT_W-1:0] cyc_reg_q, cyc_reg_d;
    logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
    logic [CNT_W-1:0] cyc_next;
    logic [DT_W-1:0]  dead_reg_q, dead_reg_d;
    logic [DT_W-1:0]  dead_cnt_q, dead_cnt_d;
    logic [3:0]       gates_q, gates_d;
    logic             busy_q, busy_d;
    logic             div_q, div_d;
    logic             done_q, done_d;
`ifdef BRIDGE_SEQ_BRAKE_EN
    localparam logic [3:0] GATES_BRAKE = 4'b0101;
    logic             brake_q, brake_d;
`endif

    // Gate order {ah, al, bh, bl}; phases 1 and 3 both freewheel on the low sides.
    function automatic logic [3:0] pattern(input logic [1:0] ph);
        case (ph)
            2'd0:    pattern = 4'b1001;
            2'd2:    pattern = 4'b0110;
            default: pattern = 4'b0101;
        endcase
    endfunction

    assign cyc_next = cyc_cnt_q + CNT_W'(1);

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        cyc_reg_d  = cyc_reg_q;
        cyc_cnt_d  = cyc_cnt_q;
        dead_reg_d = dead_reg_q;
        dead_cnt_d = dead_cnt_q;
        gates_d    = gates_q;
        busy_d     = busy_q;
        div_d      = div_q;
        done_d     = 1'b0;
`ifdef BRIDGE_SEQ_BRAKE_EN
        brake_d    = brake_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef BRIDGE_SEQ_BRAKE_EN
                if (stop || start) brake_d = 1'b0;
                gates_d = brake_d ? GATES_BRAKE : GATES_OFF;
`else
                gates_d = GATES_OFF;
`endif
                // start compares against the register value before any same-cycle load
                if (start) begin
                    if (cyc_reg_q != '0) begin
                        state_d   = ARM;
                        busy_d    = 1'b1;
                        div_d     = 1'b1;
                        cyc_cnt_d = '0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
                if (load) begin
                    cyc_reg_d  = cyc_num;
                    dead_reg_d = dead_num;
                end
            end
            ARM: begin
                gates_d = GATES_OFF;
                if (stop) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    div_d   = 1'b0;
                end else if (clk_4f_en) begin
                    state_d    = RUN;
                    phase_d    = 2'd0;
                    dead_cnt_d = dead_reg_q;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                    gates_d = GATES_OFF;
                    busy_d  = 1'b0;
                    div_d   = 1'b0;
                end else if (clk_4f_en) begin
                    // every strobe opens a dead-time window, so no leg ever switches directly
                    phase_d    = phase_q + 2'd1;
                    dead_cnt_d = dead_reg_q;
                    gates_d    = GATES_OFF;
                    if (phase_q == 2'd3) begin
                        cyc_cnt_d = cyc_next;
                        if (cyc_next == cyc_reg_q) begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                            div_d   = 1'b0;
                            done_d  = 1'b1;
`ifdef BRIDGE_SEQ_BRAKE_EN
                            brake_d = 1'b1;
                            gates_d = GATES_BRAKE;
`endif
                        end
                    end
                end else if (dead_cnt_q != '0) begin
                    dead_cnt_d = dead_cnt_q - DT_W'(1);
                    gates_d    = GATES_OFF;
                end else begin
                    gates_d = pattern(phase_q);
                end
            end
            default: begin
                state_d = IDLE;
                gates_d = GATES_OFF;
                busy_d  = 1'b0;
                div_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            phase_q    <= 2'd0;
            cyc_reg_q  <= '0;
            cyc_cnt_q  <= '0;
            dead_reg_q <= '0;
            dead_cnt_q <= '0;
            gates_q    <= GATES_OFF;
            busy_q     <= 1'b0;
            div_q      <= 1'b0;
            done_q     <= 1'b0;
`ifdef BRIDGE_SEQ_BRAKE_EN
            brake_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            cyc_reg_q  <= cyc_reg_d;
            cyc_cnt_q  <= cyc_cnt_d;
            dead_reg_q <= dead_reg_d;
            dead_cnt_q <= dead_cnt_d;
            gates_q    <= gates_d;
            busy_q     <= busy_d;
            div_q      <= div_d;
            done_q     <= done_d;
`ifdef BRIDGE_SEQ_BRAKE_EN
            brake_q    <= brake_d;
`endif
        end
    end

    assign {gate_ah, gate_al, gate_bh, gate_bl} = gates_q;
    assign bri_div_start = div_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign cyc_cnt       = cyc_cnt_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_bridge_phase_seq.sv
// Bench for bridge_phase_seq: vector table, hand-written corner sequences and random stimulus
// checked against a strobe-counting reference model.
module tb_bridge_phase_seq;

    localparam int CNT_W = 12;
    localparam int DT_W  = 4;

    logic             clk_sys = 1'b0;
    logic             rst_n;
    logic             load;
    logic [CNT_W-1:0] cyc_num;
    logic [DT_W-1:0]  dead_num;
    logic             start;
    logic             stop;
    logic             clk_4f_en;
    logic             bri_div_start;
    logic             gate_ah, gate_al, gate_bh, gate_bl;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] cyc_cnt;
    logic [1:0]       state_dbg;
    logic [3:0]       gates;

    int n_checks = 0;
    int n_fail   = 0;

    bridge_phase_seq #(.CNT_W(CNT_W), .DT_W(DT_W)) dut (
        .clk_sys       (clk_sys),
        .rst_n         (rst_n),
        .load          (load),
        .cyc_num       (cyc_num),
        .dead_num      (dead_num),
        .start         (start),
        .stop          (stop),
        .clk_4f_en     (clk_4f_en),
        .bri_div_start (bri_div_start),
        .gate_ah       (gate_ah),
        .gate_al       (gate_al),
        .gate_bh       (gate_bh),
        .gate_bl       (gate_bl),
        .busy          (busy),
        .done          (done),
        .cyc_cnt       (cyc_cnt),
        .state_dbg     (state_dbg)
    );

    assign gates = {gate_ah, gate_al, gate_bh, gate_bl};

    // ---------------- clock ----------------
    always #5 clk_sys = ~clk_sys;

    // ---------------- reference model ----------------
    // Burst described by strobe count k since start and cycles elapsed since last strobe.
    logic [3:0] pat [4];
    bit  m_busy, m_done;
    int  m_k, m_since, m_cyc, m_dead, m_cnt;

    task automatic model_step();
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_k = 0; m_since = 0;
            m_cyc = 0; m_dead = 0; m_cnt = 0;
        end else if (!m_busy) begin
            m_done = 0;
            if (start) begin
                if (m_cyc != 0) begin
                    m_busy = 1; m_k = 0; m_cnt = 0; m_since = 0;
                end else begin
                    m_done = 1;
                end
            end
            if (load) begin
                m_cyc  = int'(cyc_num);
                m_dead = int'(dead_num);
            end
        end else begin
            m_done = 0;
            if (stop) begin
                m_busy = 0;
            end else if (clk_4f_en) begin
                m_k++;
                m_since = 0;
                if (m_k > 1 && (m_k - 1) % 4 == 0) begin
                    m_cnt = (m_cnt + 1) % (1 << CNT_W);
                    if (m_cnt == m_cyc) begin
                        m_busy = 0;
                        m_done = 1;
                    end
                end
            end else if (m_since < 1000) begin
                m_since++;
            end
        end
    endtask

    function automatic logic [3:0] m_gates();
        if (m_busy && m_k >= 1 && m_since > m_dead) return pat[(m_k - 1) % 4];
        return 4'b0000;
    endfunction

    function automatic logic [1:0] m_state();
        if (!m_busy) return 2'd0;
        if (m_k == 0) return 2'd1;
        return 2'd2;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: advance the model on the edge, compare all outputs 1 time unit later.
    task automatic cycle();
        logic [31:0] act, exp;
        @(posedge clk_sys);
        model_step();
        #1;
        act = {11'd0, state_dbg, bri_div_start, busy, done, cyc_cnt, gates};
        exp = {11'd0, m_state(), m_busy, m_busy, m_done, CNT_W'(m_cnt), m_gates()};
        check("model_outputs", act, exp);
        check("no_shoot_through", {30'd0, gate_ah & gate_al, gate_bh & gate_bl}, 32'd0);
    endtask

    // ---------------- driver ----------------
    task automatic set_in(input logic ld, input int cyc, input int dt,
                          input logic st, input logic sp, input logic stb);
        load      = ld;
        cyc_num   = CNT_W'(cyc);
        dead_num  = DT_W'(dt);
        start     = st;
        stop      = sp;
        clk_4f_en = stb;
    endtask

    task automatic idle(input int n);
        set_in(0, 0, 0, 0, 0, 0);
        repeat (n) cycle();
    endtask

    task automatic strobe();
        set_in(0, 0, 0, 0, 0, 1);
        cycle();
        set_in(0, 0, 0, 0, 0, 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic             ld;
        int               cyc;
        int               dt;
        logic             st, sp, stb;
        logic             e_div, e_busy, e_done;
        logic [CNT_W-1:0] e_cnt;
        logic [3:0]       e_gates;
    } vec_t;

    function automatic vec_t mk(input logic ld, input int cyc, input int dt, input logic st,
                                input logic sp, input logic stb, input logic e_div,
                                input logic e_busy, input logic e_done, input int e_cnt,
                                input logic [3:0] e_gates);
        vec_t v;
        v.ld = ld; v.cyc = cyc; v.dt = dt; v.st = st; v.sp = sp; v.stb = stb;
        v.e_div = e_div; v.e_busy = e_busy; v.e_done = e_done;
        v.e_cnt = CNT_W'(e_cnt); v.e_gates = e_gates;
        return v;
    endfunction

    vec_t tbl [20];

    initial begin
        pat[0] = 4'b1001; pat[1] = 4'b0101; pat[2] = 4'b0110; pat[3] = 4'b0101;

        //            ld cyc dt st sp stb  div busy done cnt gates
        tbl[0]  = mk(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 4'b0000);
        tbl[1]  = mk(0, 0, 0, 1, 0, 0,   0, 0, 1, 0, 4'b0000); // zero-count start
        tbl[2]  = mk(0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 4'b0000); // stop in IDLE
        tbl[3]  = mk(1, 1, 0, 0, 0, 0,   0, 0, 0, 0, 4'b0000);
        tbl[4]  = mk(0, 0, 0, 1, 0, 0,   1, 1, 0, 0, 4'b0000);
        tbl[5]  = mk(0, 0, 0, 1, 0, 0,   1, 1, 0, 0, 4'b0000); // start while busy
        tbl[6]  = mk(0, 0, 0, 0, 0, 1,   1, 1, 0, 0, 4'b0000);
        tbl[7]  = mk(0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 4'b1001);
        tbl[8]  = mk(1, 9, 2, 0, 0, 0,   1, 1, 0, 0, 4'b1001); // load while busy
        tbl[9]  = mk(0, 0, 0, 0, 0, 1,   1, 1, 0, 0, 4'b0000);
        tbl[10] = mk(0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 4'b0101);
        tbl[11] = mk(0, 0, 0, 0, 0, 1,   1, 1, 0, 0, 4'b0000);
        tbl[12] = mk(0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 4'b0110);
        tbl[13] = mk(0, 0, 0, 0, 0, 1,   1, 1, 0, 0, 4'b0000);
        tbl[14] = mk(0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 4'b0101);
        tbl[15] = mk(0, 0, 0, 0, 0, 1,   0, 0, 1, 1, 4'b0000); // completion
        tbl[16] = mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 4'b0000);
        tbl[17] = mk(0, 0, 0, 1, 0, 0,   1, 1, 0, 0, 4'b0000);
        tbl[18] = mk(0, 0, 0, 0, 0, 1,   1, 1, 0, 0, 4'b0000);
        tbl[19] = mk(0, 0, 0, 0, 1, 1,   0, 0, 0, 0, 4'b0000); // stop beats strobe

        // reset
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0);
        cycle();
        cycle();
        check("reset_outputs", {16'd0, bri_div_start, busy, done, cyc_cnt, gates, state_dbg}, 32'd0);
        rst_n = 1'b1;
        idle(1);

        // table
        for (int i = 0; i < 20; i++) begin
            set_in(tbl[i].ld, tbl[i].cyc, tbl[i].dt, tbl[i].st, tbl[i].sp, tbl[i].stb);
            cycle();
            check($sformatf("vec_%0d", i),
                  {bri_div_start, busy, done, cyc_cnt, gates},
                  {tbl[i].e_div, tbl[i].e_busy, tbl[i].e_done, tbl[i].e_cnt, tbl[i].e_gates});
        end
        idle(2);

        // two cycles, dead time 3, strobe every 20 clocks
        set_in(1, 2, 3, 0, 0, 0); cycle();
        set_in(0, 0, 0, 1, 0, 0); cycle();
        check("a_div_on", {31'd0, bri_div_start}, 32'd1);
        idle(5);
        for (int s = 0; s < 9; s++) begin
            strobe();
            if (s < 8) begin
                for (int j = 0; j < 3; j++) begin
                    cycle();
                    check($sformatf("a_dead_s%0d_%0d", s, j), {28'd0, gates}, 32'd0);
                end
                cycle();
                check($sformatf("a_pat_s%0d", s), {28'd0, gates}, {28'd0, pat[s % 4]});
                idle(15);
            end else begin
                check("a_done", {28'd0, done, busy, bri_div_start, |gates}, 32'b1000);
                check("a_cnt", {20'd0, cyc_cnt}, 32'd2);
                idle(1);
                check("a_done_pulse", {31'd0, done}, 32'd0);
                check("a_cnt_hold", {20'd0, cyc_cnt}, 32'd2);
            end
        end

        // stop in phase 2 on the same cycle as a strobe
        set_in(1, 1, 0, 0, 0, 0); cycle();
        set_in(0, 0, 0, 1, 0, 0); cycle();
        idle(2);
        for (int s = 0; s < 3; s++) begin
            strobe();
            idle(2);
        end
        check("b_phase2", {28'd0, gates}, 32'b0110);
        set_in(0, 0, 0, 0, 1, 1); cycle();
        check("b_stop", {16'd0, bri_div_start, busy, done, cyc_cnt, gates}, 32'd0);
        idle(3);
        check("b_no_done", {31'd0, done}, 32'd0);

        // strobes closer than the dead time: gates never open, phases still count
        set_in(1, 1, 5, 0, 0, 0); cycle();
        set_in(0, 0, 0, 1, 0, 0); cycle();
        for (int s = 0; s < 5; s++) begin
            strobe();
            check($sformatf("c_off_s%0d", s), {28'd0, gates}, 32'd0);
            if (s < 4) begin
                idle(1);
                check($sformatf("c_off2_s%0d", s), {28'd0, gates}, 32'd0);
            end
        end
        check("c_done", {30'd0, done, busy}, 32'b10);
        idle(2);

        // reset mid-run while driving 1001, registers cleared afterwards
        set_in(1, 3, 0, 0, 0, 0); cycle();
        set_in(0, 0, 0, 1, 0, 0); cycle();
        strobe();
        idle(2);
        check("d_drive", {28'd0, gates}, 32'b1001);
        rst_n = 1'b0;
        cycle();
        check("d_reset", {16'd0, bri_div_start, busy, done, cyc_cnt, gates, state_dbg}, 32'd0);
        rst_n = 1'b1;
        set_in(0, 0, 0, 1, 0, 0); cycle();
        check("d_cleared_start", {30'd0, done, busy}, 32'b10);
        idle(2);

        // random stimulus against the model
        for (int i = 0; i < 1500; i++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            set_in($urandom_range(0, 7) == 0, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 5) == 0, $urandom_range(0, 59) == 0,
                   $urandom_range(0, 3) == 0);
            cycle();
        end
        rst_n = 1'b1;
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
